// File: rtl/decq_pkg.sv
// Shared types and widths for the decode issue queue and its scoreboard.
package decq_pkg;

   localparam int unsigned DECQ_NUM_ISET  = 2;
   localparam int unsigned DECQ_PAYLOAD_W = 160;
   localparam int unsigned DECQ_REG_ID_W  = 5;
   localparam int unsigned SB_W           = 2 ** DECQ_REG_ID_W;
   localparam int unsigned ISET_W         = $clog2(DECQ_NUM_ISET);

   typedef logic [ISET_W-1:0] iset_t;

   localparam iset_t ISET_ARM   = iset_t'(0);
   localparam iset_t ISET_THUMB = iset_t'(1);

   typedef struct packed {
      logic [DECQ_PAYLOAD_W-1:0] payload;
      logic [SB_W-1:0]           rs_mask;
      logic                      rd_en;
      logic [DECQ_REG_ID_W-1:0]  rd_id;
      logic                      rd2_en;
      logic [DECQ_REG_ID_W-1:0]  rd2_id;
      iset_t                     iset;
   } decq_entry_t;

endpackage

// File: rtl/decq_scoreboard.sv
// Pending-write register scoreboard: set on issue, clear on writeback, and
// RAW/WAW hazard check of one candidate entry against the registered state.
module decq_scoreboard
   import decq_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SB_W-1:0]          chk_rs_mask,
   input  logic                     chk_rd_en,
   input  logic [DECQ_REG_ID_W-1:0] chk_rd_id,
   input  logic                     chk_rd2_en,
   input  logic [DECQ_REG_ID_W-1:0] chk_rd2_id,
   input  logic                     set_en,
   input  logic                     set_rd_en,
   input  logic [DECQ_REG_ID_W-1:0] set_rd_id,
   input  logic                     set_rd2_en,
   input  logic [DECQ_REG_ID_W-1:0] set_rd2_id,
   input  logic                     wb_en,
   input  logic [DECQ_REG_ID_W-1:0] wb_id,
   input  logic                     wb2_en,
   input  logic [DECQ_REG_ID_W-1:0] wb2_id,
   output logic                     hazard_c
);

   logic [SB_W-1:0] sb_q;
   logic [SB_W-1:0] sb_d;

   // Clears first so an issue to the same register in the same cycle wins.
   always_comb begin
      sb_d = sb_q;
      if (wb_en)                sb_d[wb_id]      = 1'b0;
      if (wb2_en)               sb_d[wb2_id]     = 1'b0;
      if (set_en && set_rd_en)  sb_d[set_rd_id]  = 1'b1;
      if (set_en && set_rd2_en) sb_d[set_rd2_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sb_q <= '0;
      else     sb_q <= sb_d;
   end

   assign hazard_c = (|(chk_rs_mask & sb_q))
                   || (chk_rd_en  && sb_q[chk_rd_id])
                   || (chk_rd2_en && sb_q[chk_rd2_id]);

endmodule

// File: rtl/decode_issue_queue.sv
// Decoder channel mux, DEPTH-entry issue FIFO and scoreboard-gated issue.
// Define DECQ_BYPASS_EN for zero-latency issue through an empty queue.
module decode_issue_queue
   import decq_pkg::*;
#(
   parameter int unsigned NUM_ISET  = DECQ_NUM_ISET,
   parameter int unsigned PAYLOAD_W = DECQ_PAYLOAD_W,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned REG_ID_W  = DECQ_REG_ID_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [$clog2(NUM_ISET)-1:0]      iset_sel,
   input  logic [NUM_ISET-1:0]              in_valid,
   input  logic [NUM_ISET*PAYLOAD_W-1:0]    in_payload,
   input  logic [NUM_ISET*(2**REG_ID_W)-1:0] in_rs_mask,
   input  logic [NUM_ISET-1:0]              in_rd_en,
   input  logic [NUM_ISET-1:0]              in_rd2_en,
   input  logic [NUM_ISET*REG_ID_W-1:0]     in_rd_id,
   input  logic [NUM_ISET*REG_ID_W-1:0]     in_rd2_id,
   output logic                             in_ready,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [PAYLOAD_W-1:0]             out_payload,
   output logic                             out_rd_en,
   output logic                             out_rd2_en,
   output logic [REG_ID_W-1:0]              out_rd_id,
   output logic [REG_ID_W-1:0]              out_rd2_id,
   output logic [$clog2(NUM_ISET)-1:0]      out_iset,
   input  logic                             wb_en,
   input  logic                             wb2_en,
   input  logic [REG_ID_W-1:0]              wb_id,
   input  logic [REG_ID_W-1:0]              wb2_id,
   input  logic                             flush,
   output logic [$clog2(DEPTH):0]           count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SEL_W = $clog2(NUM_ISET);
   localparam int unsigned RS_W  = 2 ** REG_ID_W;

   decq_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt_q;

   decq_entry_t sel_entry;
   decq_entry_t head_entry;
   decq_entry_t issue_entry;
   logic        sel_valid;
   logic        empty;
   logic        full;
   logic        hazard;
   logic        bypass;
   logic        push;
   logic        pop;
   logic        fifo_pop;

   logic [SB_W-1:0]          chk_rs_mask;
   logic                     chk_rd_en;
   logic [DECQ_REG_ID_W-1:0] chk_rd_id;
   logic                     chk_rd2_en;
   logic [DECQ_REG_ID_W-1:0] chk_rd2_id;

   // Channel mux; an iset_sel with no matching channel never pushes.
   always_comb begin
      sel_entry = '0;
      sel_valid = 1'b0;
      for (int c = 0; c < NUM_ISET; c++) begin
         if (iset_sel == SEL_W'(c)) begin
            sel_valid         = in_valid[c];
            sel_entry.payload = in_payload[c*PAYLOAD_W +: PAYLOAD_W];
            sel_entry.rs_mask = in_rs_mask[c*RS_W +: RS_W];
            sel_entry.rd_en   = in_rd_en[c];
            sel_entry.rd_id   = in_rd_id[c*REG_ID_W +: REG_ID_W];
            sel_entry.rd2_en  = in_rd2_en[c];
            sel_entry.rd2_id  = in_rd2_id[c*REG_ID_W +: REG_ID_W];
            sel_entry.iset    = ISET_W'(c);
         end
      end
   end

   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == CNT_W'(DEPTH));
   assign head_entry = mem[rd_ptr];
   assign in_ready   = !full && !flush;

`ifdef DECQ_BYPASS_EN
   assign {chk_rs_mask, chk_rd_en, chk_rd_id, chk_rd2_en, chk_rd2_id} = empty
      ? {sel_entry.rs_mask, sel_entry.rd_en, sel_entry.rd_id, sel_entry.rd2_en, sel_entry.rd2_id}
      : {head_entry.rs_mask, head_entry.rd_en, head_entry.rd_id, head_entry.rd2_en, head_entry.rd2_id};
   assign bypass = empty && sel_valid && !flush && out_ready && !hazard;
`else
   assign {chk_rs_mask, chk_rd_en, chk_rd_id, chk_rd2_en, chk_rd2_id} =
      {head_entry.rs_mask, head_entry.rd_en, head_entry.rd_id, head_entry.rd2_en, head_entry.rd2_id};
   assign bypass = 1'b0;
`endif

   decq_scoreboard u_sb (
      .clk         (clk),
      .rst         (rst),
      .chk_rs_mask (chk_rs_mask),
      .chk_rd_en   (chk_rd_en),
      .chk_rd_id   (chk_rd_id),
      .chk_rd2_en  (chk_rd2_en),
      .chk_rd2_id  (chk_rd2_id),
      .set_en      (pop),
      .set_rd_en   (issue_entry.rd_en),
      .set_rd_id   (issue_entry.rd_id),
      .set_rd2_en  (issue_entry.rd2_en),
      .set_rd2_id  (issue_entry.rd2_id),
      .wb_en       (wb_en),
      .wb_id       (wb_id),
      .wb2_en      (wb2_en),
      .wb2_id      (wb2_id),
      .hazard_c    (hazard)
   );

   // Outputs track the head entry, or the bypassed bundle, else zero.
   always_comb begin
      issue_entry = '0;
      if (!empty)      issue_entry = head_entry;
      else if (bypass) issue_entry = sel_entry;
   end

   assign out_valid   = (!empty && !hazard && !flush) || bypass;
   assign out_payload = issue_entry.payload;
   assign out_rd_en   = issue_entry.rd_en;
   assign out_rd_id   = issue_entry.rd_id;
   assign out_rd2_en  = issue_entry.rd2_en;
   assign out_rd2_id  = issue_entry.rd2_id;
   assign out_iset    = issue_entry.iset;
   assign count       = cnt_q;

   assign pop      = out_valid && out_ready;
   assign fifo_pop = pop && !empty;
   assign push     = sel_valid && in_ready && !bypass;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !fifo_pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (!push && fifo_pop) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sel_entry;
   end

endmodule
